// File: rtl/cache_way_ctrl_8_if.sv
// Bundle of the request, response, refill and replacement-update signals
// between the 8-way controller and its neighbours.
interface cache_way_ctrl_8_if #(
    parameter int TAG_W  = 20,
    parameter int DATA_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic [TAG_W-1:0]  req_tag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_hit;
    logic              refill_req_valid;
    logic              refill_req_ready;
    logic [TAG_W-1:0]  refill_req_tag;
    logic              refill_rsp_valid;
    logic [DATA_W-1:0] refill_rsp_data;
    logic              flush;
    logic              hit;
    logic [7:0]        hit_sel;
    logic              plru_wen;
    logic [7:0]        wen;

    modport slave (
        input  req_valid, req_tag, rsp_ready, refill_req_ready,
               refill_rsp_valid, refill_rsp_data, flush, wen,
        output req_ready, rsp_valid, rsp_data, rsp_hit, refill_req_valid,
               refill_req_tag, hit, hit_sel, plru_wen
    );

    modport master (
        output req_valid, req_tag, rsp_ready, refill_req_ready,
               refill_rsp_valid, refill_rsp_data, flush, wen,
        input  req_ready, rsp_valid, rsp_data, rsp_hit, refill_req_valid,
               refill_req_tag, hit, hit_sel, plru_wen
    );
endinterface

// File: rtl/cache_way_ctrl_8.sv
// Single-set, 8-way lookup controller: compares a tag against all ways, refills
// on a miss and reports hits / victim requests to an external 8-way PLRU.
module cache_way_ctrl_8 #(
    parameter int TAG_W  = 20,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    cache_way_ctrl_8_if.slave  bus
);
    // state | meaning
    // IDLE  | ready for a lookup, flush allowed
    // CMP   | compare latched tag against all ways
    // REQ   | miss: refill request outstanding
    // WAIT  | waiting for refill data
    // FILL  | write refill data into a free or PLRU-chosen way
    // RESP  | response held until accepted
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMP  = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_FILL = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [7:0]        valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rsp_hit_q, rsp_hit_d;

    logic [TAG_W-1:0]  tag_mem  [8];
    logic [DATA_W-1:0] data_mem [8];

    logic [7:0]        match_sel, free_sel, wr_sel;
    logic [DATA_W-1:0] hit_data;
    logic              any_match, any_free;

    // Descending scan so the lowest index is the last (winning) assignment.
    always_comb begin
        match_sel = '0;
        free_sel  = '0;
        hit_data  = '0;
        for (int i = 7; i >= 0; i--) begin
            if (valid_q[i] && (tag_mem[i] == tag_q)) match_sel = 8'(1) << i;
            if (!valid_q[i]) free_sel = 8'(1) << i;
        end
        for (int i = 0; i < 8; i++) begin
            if (match_sel[i]) hit_data = data_mem[i];
        end
    end

    assign any_match = |match_sel;
    assign any_free  = |free_sel;

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        tag_d     = tag_q;
        data_d    = data_q;
        rsp_hit_d = rsp_hit_q;
        wr_sel    = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.flush) begin
                    valid_d = '0;
                end else if (bus.req_valid) begin
                    tag_d   = bus.req_tag;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (any_match) begin
                    data_d    = hit_data;
                    rsp_hit_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REQ: if (bus.refill_req_ready) state_d = S_WAIT;
            S_WAIT: begin
                if (bus.refill_rsp_valid) begin
                    data_d  = bus.refill_rsp_data;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                // A zero victim from the PLRU leaves the array untouched.
                wr_sel    = any_free ? free_sel : bus.wen;
                valid_d   = valid_q | wr_sel;
                rsp_hit_d = 1'b0;
                state_d   = S_RESP;
            end
            S_RESP: if (bus.rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            valid_q   <= '0;
            tag_q     <= '0;
            data_q    <= '0;
            rsp_hit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
            rsp_hit_q <= rsp_hit_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (wr_sel[i]) begin
                tag_mem[i]  <= tag_q;
                data_mem[i] <= data_q;
            end
        end
    end

    assign bus.req_ready        = (state_q == S_IDLE) && !bus.flush && !rst;
    assign bus.rsp_valid        = (state_q == S_RESP);
    assign bus.rsp_data         = (state_q == S_RESP) ? data_q : '0;
    assign bus.rsp_hit          = (state_q == S_RESP) && rsp_hit_q;
    assign bus.refill_req_valid = (state_q == S_REQ);
    assign bus.refill_req_tag   = (state_q == S_REQ) ? tag_q : '0;
    assign bus.hit              = ((state_q == S_CMP) && any_match) ||
                                  ((state_q == S_FILL) && any_free);
    assign bus.hit_sel          = ((state_q == S_CMP) && any_match) ? match_sel :
                                  ((state_q == S_FILL) && any_free) ? free_sel : 8'h00;
    assign bus.plru_wen         = (state_q == S_FILL) && !any_free;
endmodule

// File: tb/tb_cache_way_ctrl_8.sv
// Directed bench for cache_way_ctrl_8: cold miss, hit, full-set replacement,
// backpressure, flush priority and reset during a pending refill.
module tb_cache_way_ctrl_8;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_way_ctrl_8_if #(.TAG_W(20), .DATA_W(32)) bus ();
    cache_way_ctrl_8 #(.TAG_W(20), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    // observations from the last run_req transaction
    logic        r_rdy, r_refill, r_rsphit, r_done;
    logic [19:0] r_rtag;
    logic [31:0] r_data;
    logic [7:0]  r_hitsel;
    int          r_hits, r_plru, r_lat, r_reqlat, r_filllat;

    task automatic run_req(input logic [19:0] tag, input logic [31:0] rdata, input logic [7:0] wv);
        int cyc, rsp_cyc, sent;
        logic pend;
        r_refill = 0; r_rsphit = 0; r_done = 0; r_rtag = '0; r_data = '0; r_hitsel = '0;
        r_hits = 0; r_plru = 0; r_lat = -1; r_reqlat = -1; r_filllat = -1;
        cyc = 0; rsp_cyc = 0; sent = 0; pend = 0;
        @(negedge clk);
        bus.req_valid = 1; bus.req_tag = tag; bus.wen = wv;
        bus.refill_req_ready = 1; bus.rsp_ready = 1;
        r_rdy = bus.req_ready;
        @(posedge clk); #1 bus.req_valid = 0;
        while (!r_done && cyc < 50) begin
            @(negedge clk); cyc++;
            if (bus.hit) begin r_hits++; r_hitsel = bus.hit_sel; end
            if (bus.plru_wen) r_plru++;
            if (sent == 1) begin bus.refill_rsp_valid = 0; sent = 2; end
            if (bus.rsp_valid) begin
                r_done = 1; r_lat = cyc; r_data = bus.rsp_data; r_rsphit = bus.rsp_hit;
                if (sent != 0) r_filllat = cyc - rsp_cyc;
            end else if (pend && sent == 0) begin
                bus.refill_rsp_valid = 1; bus.refill_rsp_data = rdata; rsp_cyc = cyc; sent = 1;
            end
            if (bus.refill_req_valid && !pend) begin
                pend = 1; r_refill = 1; r_rtag = bus.refill_req_tag; r_reqlat = cyc;
            end
        end
        bus.refill_rsp_valid = 0;
        if (!r_done) begin n_err++; $display("FAIL req_timeout tag=%h got no rsp_valid want rsp_valid within 50 cycles", tag); end
        n_cmp++;
    endtask

    task automatic test_reset;
        rst = 1; bus.req_valid = 1; bus.req_tag = 20'h00abc;
        repeat (2) @(negedge clk);
        if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready got=%b want=0", bus.req_ready); end
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_hit, bus.refill_req_valid, bus.hit, bus.plru_wen} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl got=%b want=00000", {bus.rsp_valid, bus.rsp_hit, bus.refill_req_valid, bus.hit, bus.plru_wen}); end
        n_cmp++;
        if (bus.rsp_data !== 32'h0 || bus.refill_req_tag !== 20'h0 || bus.hit_sel !== 8'h0) begin
            n_err++; $display("FAIL reset_data got=%h/%h/%h want=0/0/0", bus.rsp_data, bus.refill_req_tag, bus.hit_sel); end
        n_cmp++;
        bus.req_valid = 0; rst = 0;
        @(negedge clk);
        if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got=%b want=1", bus.req_ready); end
        n_cmp++;
    endtask

    task automatic test_cold_miss;
        run_req(20'h12345, 32'hDEADBEEF, 8'h00);
        if (r_rdy !== 1'b1) begin n_err++; $display("FAIL cold_ready got=%b want=1", r_rdy); end
        n_cmp++;
        if (r_refill !== 1'b1 || r_rtag !== 20'h12345) begin n_err++; $display("FAIL cold_refill_tag got=%b/%h want=1/12345", r_refill, r_rtag); end
        n_cmp++;
        if (r_reqlat != 2) begin n_err++; $display("FAIL cold_req_latency got=%0d want=2", r_reqlat); end
        n_cmp++;
        if (r_hits != 1 || r_hitsel !== 8'h01 || r_plru != 0) begin
            n_err++; $display("FAIL cold_plru_port got hits=%0d sel=%h plru=%0d want 1/01/0", r_hits, r_hitsel, r_plru); end
        n_cmp++;
        if (r_data !== 32'hDEADBEEF || r_rsphit !== 1'b0) begin n_err++; $display("FAIL cold_rsp got=%h/%b want=deadbeef/0", r_data, r_rsphit); end
        n_cmp++;
        if (r_filllat != 2) begin n_err++; $display("FAIL cold_fill_latency got=%0d want=2", r_filllat); end
        n_cmp++;
    endtask

    task automatic test_hit;
        run_req(20'h12345, 32'h0BADF00D, 8'h00);
        if (r_refill !== 1'b0) begin n_err++; $display("FAIL hit_no_refill got=%b want=0", r_refill); end
        n_cmp++;
        if (r_lat != 2) begin n_err++; $display("FAIL hit_latency got=%0d want=2", r_lat); end
        n_cmp++;
        if (r_rsphit !== 1'b1 || r_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL hit_rsp got=%b/%h want=1/deadbeef", r_rsphit, r_data); end
        n_cmp++;
        if (r_hits != 1 || r_hitsel !== 8'h01 || r_plru != 0) begin
            n_err++; $display("FAIL hit_plru_port got hits=%0d sel=%h plru=%0d want 1/01/0", r_hits, r_hitsel, r_plru); end
        n_cmp++;
    endtask

    task automatic test_full_set;
        logic [7:0] exp_sel;
        for (int i = 0; i < 7; i++) begin
            exp_sel = 8'h01 << (i + 1);
            run_req(20'h00100 + 20'(i), 32'hA0000000 + 32'(i), 8'h00);
            if (r_refill !== 1'b1 || r_hitsel !== exp_sel || r_plru != 0) begin
                n_err++; $display("FAIL fill_way%0d got refill=%b sel=%h plru=%0d want 1/%h/0", i + 1, r_refill, r_hitsel, r_plru, exp_sel); end
            n_cmp++;
        end
        run_req(20'h00999, 32'h99990000, 8'h20);
        if (r_plru != 1 || r_hits != 0) begin n_err++; $display("FAIL full_plru got plru=%0d hits=%0d want 1/0", r_plru, r_hits); end
        n_cmp++;
        if (r_data !== 32'h99990000 || r_rsphit !== 1'b0) begin n_err++; $display("FAIL full_rsp got=%h/%b want=99990000/0", r_data, r_rsphit); end
        n_cmp++;
        run_req(20'h00999, 32'h0, 8'h00);
        if (r_refill !== 1'b0 || r_hitsel !== 8'h20 || r_data !== 32'h99990000) begin
            n_err++; $display("FAIL way5_new got refill=%b sel=%h data=%h want 0/20/99990000", r_refill, r_hitsel, r_data); end
        n_cmp++;
        run_req(20'h00104, 32'h10410410, 8'h20);
        if (r_refill !== 1'b1) begin n_err++; $display("FAIL way5_old_miss got refill=%b want=1", r_refill); end
        n_cmp++;
        run_req(20'h00777, 32'h77770000, 8'h00);
        if (r_plru != 1 || r_data !== 32'h77770000 || r_rsphit !== 1'b0) begin
            n_err++; $display("FAIL wen_zero got plru=%0d data=%h hit=%b want 1/77770000/0", r_plru, r_data, r_rsphit); end
        n_cmp++;
        run_req(20'h00777, 32'h77770001, 8'h00);
        if (r_refill !== 1'b1) begin n_err++; $display("FAIL wen_zero_not_written got refill=%b want=1", r_refill); end
        n_cmp++;
    endtask

    task automatic test_backpressure;
        int k;
        @(negedge clk);
        bus.req_valid = 1; bus.req_tag = 20'h00555; bus.refill_req_ready = 0; bus.rsp_ready = 1; bus.wen = 8'h01;
        @(posedge clk); #1 bus.req_valid = 0;
        k = 0;
        do begin @(negedge clk); k++; end while (!bus.refill_req_valid && k < 20);
        if (bus.refill_req_valid !== 1'b1) begin n_err++; $display("FAIL bp_refill_timeout got=%b want=1", bus.refill_req_valid); end
        n_cmp++;
        for (int i = 0; i < 5; i++) begin
            if (bus.refill_req_valid !== 1'b1 || bus.refill_req_tag !== 20'h00555) begin
                n_err++; $display("FAIL bp_refill_hold cyc%0d got=%b/%h want=1/00555", i, bus.refill_req_valid, bus.refill_req_tag); end
            n_cmp++;
            @(negedge clk);
        end
        bus.refill_req_ready = 1; bus.rsp_ready = 0;
        @(negedge clk);
        bus.refill_req_ready = 0; bus.refill_rsp_valid = 1; bus.refill_rsp_data = 32'hCAFEF00D;
        @(negedge clk);
        bus.refill_rsp_valid = 0;
        if (bus.plru_wen !== 1'b1 || bus.hit !== 1'b0) begin n_err++; $display("FAIL bp_fill got plru=%b hit=%b want 1/0", bus.plru_wen, bus.hit); end
        n_cmp++;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hCAFEF00D || bus.rsp_hit !== 1'b0) begin
                n_err++; $display("FAIL bp_rsp_hold cyc%0d got=%b/%h/%b want=1/cafef00d/0", i, bus.rsp_valid, bus.rsp_data, bus.rsp_hit); end
            n_cmp++;
            if (i < 3) @(negedge clk);
        end
        bus.rsp_ready = 1;
        @(negedge clk);
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_release got rsp_valid=%b req_ready=%b want 0/1", bus.rsp_valid, bus.req_ready); end
        n_cmp++;
    endtask

    task automatic test_flush;
        run_req(20'h00555, 32'h0, 8'h00);
        if (r_refill !== 1'b0 || r_data !== 32'hCAFEF00D) begin n_err++; $display("FAIL preflush_hit got refill=%b data=%h want 0/cafef00d", r_refill, r_data); end
        n_cmp++;
        @(negedge clk);
        bus.flush = 1; bus.req_valid = 1; bus.req_tag = 20'h00555;
        #1;
        if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got=%b want=0", bus.req_ready); end
        n_cmp++;
        @(posedge clk); #1 bus.flush = 0; bus.req_valid = 0;
        run_req(20'h00555, 32'h55550000, 8'h00);
        if (r_rdy !== 1'b1 || r_refill !== 1'b1 || r_hitsel !== 8'h01) begin
            n_err++; $display("FAIL flush_miss got rdy=%b refill=%b sel=%h want 1/1/01", r_rdy, r_refill, r_hitsel); end
        n_cmp++;
    endtask

    task automatic test_reset_wait;
        int k;
        @(negedge clk);
        bus.req_valid = 1; bus.req_tag = 20'h00321; bus.refill_req_ready = 1; bus.rsp_ready = 1;
        @(posedge clk); #1 bus.req_valid = 0;
        k = 0;
        do begin @(negedge clk); k++; end while (!bus.refill_req_valid && k < 20);
        if (bus.refill_req_valid !== 1'b1) begin n_err++; $display("FAIL rw_refill_timeout got=%b want=1", bus.refill_req_valid); end
        n_cmp++;
        @(negedge clk);
        rst = 1;
        #1;
        if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.refill_req_valid !== 1'b0) begin
            n_err++; $display("FAIL rw_in_reset got rdy=%b rsp=%b refill=%b want 0/0/0", bus.req_ready, bus.rsp_valid, bus.refill_req_valid); end
        n_cmp++;
        @(negedge clk);
        rst = 0; bus.refill_rsp_valid = 1; bus.refill_rsp_data = 32'h11111111;
        @(negedge clk);
        bus.refill_rsp_valid = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.rsp_valid !== 1'b0 || bus.hit !== 1'b0 || bus.req_ready !== 1'b1) begin
                n_err++; $display("FAIL rw_idle cyc%0d got rsp=%b hit=%b rdy=%b want 0/0/1", i, bus.rsp_valid, bus.hit, bus.req_ready); end
            n_cmp++;
            @(negedge clk);
        end
        run_req(20'h00555, 32'h5A5A5A5A, 8'h00);
        if (r_refill !== 1'b1 || r_hitsel !== 8'h01) begin
            n_err++; $display("FAIL rw_cleared got refill=%b sel=%h want 1/01", r_refill, r_hitsel); end
        n_cmp++;
    endtask

    initial begin
        bus.req_valid = 0; bus.req_tag = '0; bus.rsp_ready = 0; bus.refill_req_ready = 0;
        bus.refill_rsp_valid = 0; bus.refill_rsp_data = '0; bus.flush = 0; bus.wen = '0;
        rst = 1;
        test_reset();
        test_cold_miss();
        test_hit();
        test_full_set();
        test_backpressure();
        test_flush();
        test_reset_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cache_way_ctrl_8.md
CACHE_WAY_CTRL_8 -- requirements
Module: cache_way_ctrl_8

Interface
REQ-001 SHALL have parameter TAG_W, default 20, lookup tag width.
REQ-002 SHALL have parameter DATA_W, default 32, per-entry payload width.
REQ-003 SHALL have clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have req_valid/req_ready  in/out  1/1  lookup request handshake; req_tag  input  TAG_W.
REQ-006 SHALL have rsp_valid/rsp_ready  out/in  1/1  response handshake; rsp_data  output  DATA_W; rsp_hit  output  1  (1 = served from the array).
REQ-007 SHALL have refill_req_valid/refill_req_ready  out/in  1/1  miss request handshake; refill_req_tag  output  TAG_W.
REQ-008 SHALL have refill_rsp_valid  input  1  refill data strobe; refill_rsp_data  input  DATA_W.
REQ-009 SHALL have flush  input  1  invalidate all entries.
REQ-010 SHALL have hit  output  1, hit_sel  output  8, plru_wen  output  1: the replacement-update port, driven to the 8-way PLRU.
REQ-011 SHALL have wen  input  8: the one-hot victim returned combinationally by the PLRU in the same cycle as plru_wen.

Function
REQ-012 SHALL hold 8 entries, each with a valid bit, a TAG_W tag and DATA_W data.
REQ-013 SHALL implement the FSM states IDLE, CMP, REQ, WAIT, FILL and RESP.
REQ-014 IDLE: req_ready=1 unless flush=1; on req_valid&req_ready, latch req_tag and go to CMP.
REQ-015 flush in IDLE: clear all valid bits that cycle; flush takes priority over req_valid (req_ready=0); flush in any other state is ignored.
REQ-016 CMP: a way matches when valid and tag equal; on multiple matches the lowest index wins.
REQ-017 CMP on a hit: pulse hit=1 with one-hot hit_sel for one cycle, latch that way's data, set rsp_hit=1 and go to RESP.
REQ-018 CMP on a miss: go to REQ with no PLRU port activity.
REQ-019 REQ: drive refill_req_valid=1 with refill_req_tag equal to the latched tag; hold both stable until refill_req_ready; then go to WAIT.
REQ-020 WAIT: on refill_rsp_valid, latch refill_rsp_data and go to FILL; refill_rsp_valid in any other state is ignored.
REQ-021 FILL with any invalid way: write the lowest-index invalid way (valid=1, latched tag, latched data) and pulse hit=1 with hit_sel equal to that way; plru_wen=0.
REQ-022 FILL with all 8 ways valid: pulse plru_wen=1 and overwrite the way selected by wen in the same cycle; hit=0.
REQ-023 FILL when wen=0 under REQ-022: write no entry and still proceed.
REQ-024 FILL SHALL always exit to RESP with rsp_hit=0 and rsp_data equal to the refill data.
REQ-025 RESP: hold rsp_valid=1 and stable rsp_data/rsp_hit until rsp_ready; then go to IDLE.
REQ-026 hit and plru_wen SHALL never be high in the same cycle, and each SHALL be high for at most one cycle per request.
REQ-027 hit_sel SHALL be 0 whenever hit=0.
REQ-028 Latency: a hit gives rsp_valid 2 cycles after acceptance; a miss gives refill_req_valid 2 cycles after acceptance and rsp_valid 2 cycles after the refill_rsp_valid cycle.
REQ-029 SHALL have one request outstanding at most; req_ready=0 outside IDLE.

Reset
REQ-030 rst=1 SHALL force IDLE and clear all valid bits, regardless of the current state.
REQ-031 During rst=1, all of these outputs SHALL be 0: rsp_valid, rsp_hit, rsp_data, refill_req_valid, refill_req_tag, hit, hit_sel, plru_wen.
REQ-032 During rst=1, req_ready SHALL be 0.
REQ-033 A reset asserted mid-miss SHALL abandon the refill without writing the entry; a later refill_rsp_valid is ignored.
REQ-034 Tag and data storage need not be reset.

Verification
REQ-035 Cold miss: after reset, request tag 0x12345, refill data 0xDEADBEEF -> refill_req_tag=0x12345; way 0 written; hit=1 with hit_sel=0x01; rsp_data=0xDEADBEEF; rsp_hit=0.
REQ-036 Hit: re-request 0x12345 -> rsp_valid 2 cycles after acceptance; rsp_hit=1; hit_sel=0x01; no refill request.
REQ-037 Full set: fill 8 distinct tags, then miss on a ninth with wen=0x20 -> plru_wen=1 for exactly one cycle; way 5 overwritten; a following lookup of the old way-5 tag misses.
REQ-038 Backpressure: hold refill_req_ready=0 for 5 cycles, then rsp_ready=0 for 3 cycles -> refill_req_valid and tag held stable; rsp_valid and data held stable; completes on release.
REQ-039 Flush priority: flush=1 and req_valid=1 in the same IDLE cycle -> req_ready=0; all entries invalid; the next request to a previously cached tag misses.
REQ-040 Reset in WAIT: assert rst, then drive refill_rsp_valid -> no entry valid; no rsp_valid; FSM in IDLE.
